// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and constants for the FIFO read-side stream
//               adapter: buffer occupancy states and the handshake counter
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_WORD_COUNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // Number of words held in the output buffer for a given state.
    function automatic logic [1:0] occ_count(input occ_state_t s);
        case (s)
            EMPTY:   occ_count = 2'd0;
            ONE:     occ_count = 2'd1;
            default: occ_count = 2'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Drains the read port of a FIFO (1-cycle read latency) into a
//               valid/ready stream through a 2-entry in-order buffer.
//               Counts completed handshakes and flags protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      rd_clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty,
    input  logic                      fifo_valid,
    input  logic [DATA_WIDTH-1:0]     fifo_rdata,
    input  logic                      fifo_underflow,
    output logic                      fifo_rd_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_WIDTH-1:0]     m_data,
    output logic [c_WORD_COUNT_W-1:0] word_count,
    output logic                      err
);

    occ_state_t                r_state;
    occ_state_t                w_state_nxt;
    logic                      r_inflight;
    logic [DATA_WIDTH-1:0]     r_slot0;
    logic [DATA_WIDTH-1:0]     r_slot1;
    logic                      r_head;
    logic                      r_tail;
    logic [DATA_WIDTH-1:0]     r_m_data;
    logic [c_WORD_COUNT_W-1:0] r_word_count;
    logic                      r_err;

    logic                      w_pop;
    logic                      w_overrun;
    logic                      w_accept;
    logic                      w_err_set;
    logic [2:0]                w_level;
    logic                      w_head_nxt;
    logic [DATA_WIDTH-1:0]     w_slot0_nxt;
    logic [DATA_WIDTH-1:0]     w_slot1_nxt;

    // m_valid decodes straight from the state register, so m_ready only
    // reaches outputs through the read-request path below.
    assign m_valid = (r_state != EMPTY);
    assign w_pop   = m_valid && m_ready;

    // Projected occupancy once this cycle's pop and the in-flight word land;
    // a new read is issued only if that leaves room.
    assign w_level    = {1'b0, occ_count(r_state)} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en = rst_n && !fifo_empty && (w_level < 3'd2);

    // A data beat without a matching read is spurious and dropped; a beat
    // into a full buffer that is not draining is dropped to keep contents.
    assign w_overrun = fifo_valid && r_inflight && (r_state == TWO) && !w_pop;
    assign w_accept  = fifo_valid && r_inflight && !w_overrun;
    assign w_err_set = (fifo_valid && !r_inflight) || fifo_underflow || w_overrun;

    // Occupancy next-state: arrival increments, pop decrements, both hold.
    always_comb begin
        w_state_nxt = r_state;
        case ({w_accept, w_pop})
            2'b10: begin
                case (r_state)
                    EMPTY:   w_state_nxt = ONE;
                    default: w_state_nxt = TWO;
                endcase
            end
            2'b01: begin
                case (r_state)
                    TWO:     w_state_nxt = ONE;
                    default: w_state_nxt = EMPTY;
                endcase
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Buffer slot write at the tail and head advance on pop.
    always_comb begin
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        if (w_accept) begin
            if (r_tail) begin
                w_slot1_nxt = fifo_rdata;
            end else begin
                w_slot0_nxt = fifo_rdata;
            end
        end
        w_head_nxt = r_head ^ w_pop;
    end

    // Occupancy state and read-in-flight tracking.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd_en;
        end
    end

    // Buffer storage, pointers and the registered head word.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot0  <= '0;
            r_slot1  <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_m_data <= '0;
        end else begin
            r_slot0  <= w_slot0_nxt;
            r_slot1  <= w_slot1_nxt;
            r_head   <= w_head_nxt;
            r_tail   <= r_tail ^ w_accept;
            r_m_data <= w_head_nxt ? w_slot1_nxt : w_slot0_nxt;
        end
    end

    // Handshake counter (wraps) and sticky error flag.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_pop) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_data     = r_m_data;
    assign word_count = r_word_count;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream. Emulates a FIFO read
//               port with a queue and checks the stream against a queue
//               model of the 2-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    logic        rd_clk;
    logic        rst_n;
    logic        fifo_empty;
    logic        fifo_valid;
    logic [7:0]  fifo_rdata;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [15:0] word_count;
    logic        err;

    fifo_rd_stream #(.DATA_WIDTH(8)) u_dut (
        .rd_clk         (rd_clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_valid     (fifo_valid),
        .fifo_rdata     (fifo_rdata),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .word_count     (word_count),
        .err            (err)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  buf_q[$];
    bit          inflight_m = 1'b0;
    logic [15:0] wc_exp     = 16'h0;
    bit          err_exp    = 1'b0;
    int          n_pops     = 0;
    int          n_reads    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: set ready, check outputs at the falling edge against
    // the model, advance the model, then emulate the FIFO read port.
    task automatic step(input bit rdy);
        int occ;
        bit pop_e;
        bit rd_e;
        bit rd_act;
        m_ready    = rdy;
        fifo_empty = (src_q.size() == 0);
        @(negedge rd_clk);
        occ   = buf_q.size();
        pop_e = (occ > 0) && rdy;
        rd_e  = !fifo_empty && ((occ + int'(inflight_m) - int'(pop_e)) < 2);
        chk("m_valid", {31'b0, m_valid}, {31'b0, occ > 0});
        if (occ > 0) chk("m_data", {24'b0, m_data}, {24'b0, buf_q[0]});
        chk("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, rd_e});
        chk("word_count", {16'b0, word_count}, {16'b0, wc_exp});
        chk("err", {31'b0, err}, {31'b0, err_exp});
        if (pop_e) begin
            void'(buf_q.pop_front());
            wc_exp++;
            n_pops++;
        end
        if (fifo_underflow) err_exp = 1'b1;
        if (fifo_valid) begin
            if (!inflight_m)               err_exp = 1'b1;
            else if (occ == 2 && !pop_e)   err_exp = 1'b1;
            else                           buf_q.push_back(fifo_rdata);
        end
        inflight_m = (fifo_rd_en === 1'b1);
        rd_act     = inflight_m && (src_q.size() > 0);
        if (rd_act) n_reads++;
        @(posedge rd_clk);
        #1;
        fifo_underflow = 1'b0;
        if (rd_act) begin
            fifo_valid = 1'b1;
            fifo_rdata = src_q.pop_front();
        end else begin
            fifo_valid = 1'b0;
        end
    endtask

    // Asynchronous reset taken mid-cycle, checked before any clock edge.
    task automatic do_reset();
        rst_n          = 1'b0;
        fifo_valid     = 1'b0;
        fifo_underflow = 1'b0;
        fifo_empty     = 1'b0;
        #1;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", {24'b0, m_data}, 32'd0);
        chk("rst_word_count", {16'b0, word_count}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_fifo_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        buf_q.delete();
        inflight_m = 1'b0;
        wc_exp     = 16'h0;
        err_exp    = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        rst_n      = 1'b1;
        fifo_empty = (src_q.size() == 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r0;
        int pushed;
        int fed;
        int guard;

        rst_n          = 1'b0;
        m_ready        = 1'b0;
        fifo_empty     = 1'b1;
        fifo_valid     = 1'b0;
        fifo_rdata     = 8'h00;
        fifo_underflow = 1'b0;
        #1;
        chk("init_m_valid", {31'b0, m_valid}, 32'd0);
        chk("init_m_data", {24'b0, m_data}, 32'd0);
        chk("init_word_count", {16'b0, word_count}, 32'd0);
        chk("init_err", {31'b0, err}, 32'd0);
        chk("init_fifo_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        repeat (2) @(posedge rd_clk);
        #1;
        rst_n = 1'b1;

        // Two preloaded words with the sink always ready.
        src_q.push_back(8'hA5);
        src_q.push_back(8'h3C);
        r0 = n_reads;
        p0 = n_pops;
        repeat (6) step(1'b1);
        chk("pre2_reads", n_reads - r0, 32'd2);
        chk("pre2_pops", n_pops - p0, 32'd2);
        chk("pre2_word_count", {16'b0, word_count}, 32'd2);
        chk("pre2_err", {31'b0, err}, 32'd0);

        // Sixteen words against a stalled sink, then full-rate drain.
        src_q.push_back(8'hFF);
        for (int i = 0; i < 15; i++) src_q.push_back(8'(i));
        r0 = n_reads;
        repeat (8) step(1'b0);
        chk("stall_reads", n_reads - r0, 32'd2);
        chk("stall_head", {24'b0, m_data}, 32'h0000_00FF);
        p0 = n_pops;
        repeat (16) step(1'b1);
        chk("drain_no_gap", n_pops - p0, 32'd16);
        repeat (2) step(1'b1);

        // Alternating ready over sixteen random words.
        for (int i = 0; i < 16; i++) src_q.push_back(8'($urandom));
        p0 = n_pops;
        for (int i = 0; i < 40; i++) step((i % 2) == 0);
        chk("toggle_pops", n_pops - p0, 32'd16);

        // Random refill and random backpressure.
        p0     = n_pops;
        pushed = 0;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3) == 0 && src_q.size() < 8) begin
                src_q.push_back(8'($urandom));
                pushed++;
            end
            step(1'($urandom % 2));
        end
        repeat (40) step(1'b1);
        chk("random_pops", n_pops - p0, pushed);

        // Spurious data beat with no read outstanding.
        src_q.push_back(8'h77);
        repeat (3) step(1'b0);
        fifo_valid = 1'b1;
        fifo_rdata = 8'hEE;
        step(1'b0);
        step(1'b0);
        chk("spurious_err", {31'b0, err}, 32'd1);
        chk("spurious_data", {24'b0, m_data}, 32'h0000_0077);
        step(1'b1);
        repeat (3) step(1'b0);
        chk("spurious_sticky", {31'b0, err}, 32'd1);
        do_reset();

        // Underflow pulse, then asynchronous reset with data pending.
        for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
        repeat (2) step(1'b1);
        repeat (3) step(1'b0);
        fifo_underflow = 1'b1;
        step(1'b0);
        step(1'b0);
        chk("underflow_err", {31'b0, err}, 32'd1);
        chk("underflow_valid_held", {31'b0, m_valid}, 32'd1);
        src_q.delete();
        do_reset();

        // Counter wrap: 65535 handshakes, then one more.
        p0    = n_pops;
        fed   = 0;
        guard = 0;
        while ((n_pops - p0) < 65535 && guard < 70000) begin
            if (src_q.size() < 4 && fed < 65536) begin
                src_q.push_back(8'h5A);
                fed++;
            end
            step(1'b1);
            guard++;
        end
        chk("wrap_ffff", {16'b0, word_count}, 32'h0000_FFFF);
        if (src_q.size() < 4 && fed < 65536) begin
            src_q.push_back(8'h5A);
            fed++;
        end
        repeat (4) step(1'b1);
        chk("wrap_pops", n_pops - p0, 32'd65536);
        chk("wrap_zero", {16'b0, word_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 rd_clk  input  1  single clock; rising edge; same clock as async_fifo read side.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 fifo_empty  input  1  FIFO empty flag, rd_clk domain.
REQ-005 fifo_valid  input  1  FIFO read-data valid, asserted the cycle after an accepted read.
REQ-006 fifo_rdata  input  DATA_WIDTH  FIFO read data, qualified by fifo_valid.
REQ-007 fifo_underflow  input  1  FIFO underflow pulse.
REQ-008 fifo_rd_en  output  1  FIFO read request, combinational.
REQ-009 m_valid  output  1  stream data valid, registered.
REQ-010 m_ready  input  1  downstream ready.
REQ-011 m_data  output  DATA_WIDTH  stream data, registered head of buffer.
REQ-012 word_count  output  16  number of completed stream handshakes.
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 Block SHALL drain the FIFO read port into a valid/ready stream through a 2-entry in-order buffer.
REQ-015 Buffer occupancy state machine SHALL have states EMPTY, ONE, TWO: arrival only -> +1; pop only -> -1; arrival and pop together -> no change.
REQ-016 pop SHALL be m_valid && m_ready; m_valid SHALL equal (state != EMPTY).
REQ-017 inflight (1 bit) SHALL be set the cycle after fifo_rd_en=1 and cleared otherwise; FIFO read latency is exactly 1.
REQ-018 fifo_rd_en SHALL be !fifo_empty && (occupancy + inflight - pop) < 2.
REQ-019 Steady state with m_ready=1 and FIFO non-empty SHALL sustain one word per cycle.
REQ-020 Arrival (fifo_valid=1) SHALL write fifo_rdata to the tail slot; output order SHALL equal FIFO order.
REQ-021 m_data/m_valid SHALL be held stable while m_valid=1 and m_ready=0.
REQ-022 fifo_rd_en SHALL be 0 whenever fifo_empty=1, regardless of m_ready.
REQ-023 word_count SHALL increment on each pop, wrapping 0xFFFF -> 0x0000.
REQ-024 err SHALL set on fifo_valid=1 with inflight=0, on fifo_underflow=1, or on an arrival in state TWO without pop; err SHALL clear only on reset.
REQ-025 On an error arrival in state TWO the incoming word SHALL be dropped and buffer contents preserved.
REQ-026 The m_ready -> fifo_rd_en combinational path is the only input-to-output path permitted.

Reset
REQ-027 On rst_n=0, asynchronously: state EMPTY, inflight 0, m_valid 0, m_data 0, word_count 0, err 0.
REQ-028 fifo_rd_en SHALL be 0 while rst_n=0.
REQ-029 A word in flight when reset asserts SHALL be discarded; after release, fifo_valid with inflight=0 sets err.
REQ-030 Reset release is synchronised externally; first fifo_rd_en can occur the first rd_clk edge after release.

Structure
REQ-031 Shared package fifo_pkg SHALL hold the occupancy state enum (EMPTY/ONE/TWO) and the word_count width constant (16).
REQ-032 Single module, no sub-modules; 2-entry buffer implemented as two registers with head/tail pointer bits.

Verification
REQ-033 FIFO preloaded with 0xA5, 0x3C; m_ready=1 -> fifo_rd_en on 2 consecutive cycles; m_data 0xA5 then 0x3C on consecutive cycles; word_count=2; err=0.
REQ-034 16 words 0xFF,0x00..0x0E, m_ready=0 -> exactly 2 reads issued, m_data=0xFF held; m_ready=1 -> all 16 words in order, no gaps.
REQ-035 m_ready toggling 1,0,1,0 over 16 words -> no loss, no duplication, fifo_rd_en never 1 when fifo_empty=1.
REQ-036 fifo_valid pulse injected with no read issued -> err=1 next cycle and stays 1; stream data unchanged.
REQ-037 fifo_underflow pulse -> err=1; rst_n low -> err=0, word_count=0, m_valid=0 asynchronously.
REQ-038 word_count preset near wrap by 65535 handshakes of 0x5A, then one more -> word_count=0x0000.
